// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller for the MEM stage: range/alignment checks,
// sign/zero-extended loads and read-modify-write sub-word stores.
module dmem_access_ctrl #(
    parameter logic [31:0] MEM_BASE  = 32'h01000000,
    parameter logic [31:0] MEM_BYTES = 32'h00100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [31:0] mem_addr,
    output logic        mem_read_write,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state, state_nx;
    logic        wr_q, uns_q, fault_q;
    logic [31:0] addr_q, wdata_q, rdword_q, rdata_q;
    logic [1:0]  size_q;

    logic        accept, fault;
    logic [2:0]  nbytes;
    logic [32:0] acc_end, mem_end;
    logic [31:0] merged, ld_ext;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    assign accept = req_valid && (state == IDLE);

    // Bounds are checked in 33 bits so an access wrapping past 2^32 faults.
    always_comb begin
        nbytes = 3'd0;
        case (req_size)
            2'd0:    nbytes = 3'd1;
            2'd1:    nbytes = 3'd2;
            2'd2:    nbytes = 3'd4;
            default: nbytes = 3'd0;
        endcase
    end

    assign acc_end = {1'b0, req_addr} + {30'd0, nbytes};
    assign mem_end = {1'b0, MEM_BASE} + {1'b0, MEM_BYTES};

    assign fault = (req_size == 2'd3)
                || (req_size == 2'd1 && req_addr[0])
                || (req_size == 2'd2 && req_addr[1:0] != 2'b00)
                || (req_addr < MEM_BASE)
                || (acc_end > mem_end);

    // Load lane select and extension, from the live memory word in RD.
    always_comb begin
        ld_b   = mem_data_out[{addr_q[1:0], 3'b000} +: 8];
        ld_h   = mem_data_out[{addr_q[1], 4'b0000} +: 16];
        ld_ext = mem_data_out;
        case (size_q)
            2'd0:    ld_ext = {{24{ld_b[7] & ~uns_q}}, ld_b};
            2'd1:    ld_ext = {{16{ld_h[15] & ~uns_q}}, ld_h};
            default: ld_ext = mem_data_out;
        endcase
    end

    // Sub-word store: overwrite only the addressed lane of the captured word.
    always_comb begin
        merged = rdword_q;
        case (size_q)
            2'd0:    merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            2'd1:    merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) begin
                if (fault)                             state_nx = RESP;
                else if (req_write && req_size == 2'd2) state_nx = WR;
                else                                    state_nx = RD;
            end
            RD:      state_nx = wr_q ? WR : RESP;
            WR:      state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wr_q     <= 1'b0;
            uns_q    <= 1'b0;
            fault_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
            rdword_q <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                wr_q    <= req_write;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                size_q  <= req_size;
                fault_q <= fault;
                rdata_q <= '0;
            end
            if (state == RD) begin
                rdword_q <= mem_data_out;
                if (!wr_q) rdata_q <= ld_ext;
            end
        end
    end

    assign req_ready      = (state == IDLE);
    assign rsp_valid      = (state == RESP);
    assign rsp_rdata      = (state == RESP) ? rdata_q : 32'd0;
    assign rsp_fault      = (state == RESP) && fault_q;
    assign mem_addr       = (state == RD || state == WR) ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_read_write = (state == WR);
    assign mem_data_in    = (state == WR) ? merged : 32'd0;

endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 SHALL have parameter MEM_BASE, default 32'h01000000: byte address of the first data-memory location.
REQ-002 SHALL have parameter MEM_BYTES, default 32'h00100000: data-memory size in bytes.
REQ-003 SHALL have port clock  input  1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1: MEM-stage request present.
REQ-006 SHALL have port req_ready  output  1: controller can accept a request.
REQ-007 SHALL have port req_write  input  1: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32: byte address.
REQ-009 SHALL have port req_wdata  input  32: store data, right-aligned.
REQ-010 SHALL have port req_size  input  2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-011 SHALL have port req_unsigned  input  1: load zero-extends when 1 and sign-extends when 0.
REQ-012 SHALL have port rsp_valid  output  1: one-cycle completion pulse.
REQ-013 SHALL have port rsp_rdata  output  32: extended load data; 0 for stores and faults.
REQ-014 SHALL have port rsp_fault  output  1: request rejected without any memory write.
REQ-015 SHALL have port mem_addr  output  32: word-aligned address to the data memory.
REQ-016 SHALL have port mem_read_write  output  1: memory write enable, level-sensitive.
REQ-017 SHALL have port mem_data_in  output  32: full word written to memory.
REQ-018 SHALL have port mem_data_out  input  32: combinational read word from memory.

Function
REQ-019 SHALL implement the states IDLE, RD, WR and RESP with a registered state variable.
REQ-020 SHALL drive req_ready = 1 only in IDLE.
- A request is accepted on a rising edge where req_valid & req_ready.
- On acceptance the controller registers write, addr, wdata, size and unsigned.
REQ-021 SHALL treat an accepted request as a fault when any of these holds:
- size == 3;
- half-word with addr[0] set;
- word with addr[1:0] != 0;
- addr < MEM_BASE;
- addr + access bytes > MEM_BASE + MEM_BYTES, computed in 33 bits so wrap-around counts as a fault.
REQ-022 SHALL route each accepted request from IDLE as follows:
- fault -> RESP;
- load -> RD;
- word store -> WR;
- byte or half-word store -> RD.
REQ-023 SHALL drive mem_addr = {addr[31:2], 2'b00} in RD and WR, and hold it at 0 in IDLE and RESP.
REQ-024 SHALL assert mem_read_write only in WR, for exactly one cycle per store, and never for a faulted request.
REQ-025 SHALL, in RD, register mem_data_out at the closing edge.
- Load: next state RESP.
- Sub-word store: next state WR.
REQ-026 SHALL build the sub-word store data by read-modify-write.
- Start from the captured word.
- Replace byte lane addr[1:0] (byte) or half lane addr[1] (half) with the low bits of wdata.
- Leave all other lanes unchanged.
- Word stores write wdata directly.
REQ-027 SHALL hold mem_data_in at 0 in every state other than WR.
REQ-028 SHALL extract load data by selecting the lane given by addr[1:0] (byte) or addr[1] (half), then extending to 32 bits per req_unsigned.
REQ-029 SHALL, in RESP, assert rsp_valid for one cycle with registered rsp_rdata and rsp_fault, then return to IDLE.
REQ-030 SHALL meet these latencies from the acceptance edge to rsp_valid high:
- load: 2 cycles;
- word store: 2 cycles;
- sub-word store: 3 cycles;
- fault: 1 cycle.
REQ-031 SHALL ignore req_valid and all req_* inputs outside IDLE; a new request may be accepted the cycle after RESP.

Reset
REQ-032 SHALL, while reset is low, immediately force the following, regardless of clock:
- state = IDLE;
- req_ready = 1;
- rsp_valid = 0, rsp_fault = 0, rsp_rdata = 0;
- mem_addr = 0, mem_read_write = 0, mem_data_in = 0.
REQ-033 SHALL abort any in-flight request on reset without issuing a response; a write cut off mid-WR is the only permitted partial effect.

Verification
REQ-034 Word store: addr 0x01000010, wdata 0xDEADBEEF, size 2 -> one WR cycle, mem_addr 0x01000010, mem_data_in 0xDEADBEEF, rsp_valid 2 cycles after accept, rsp_fault 0.
REQ-035 Byte store: memory word at 0x01000010 = 0xDEADBEEF; store addr 0x01000012, wdata 0x000000AA, size 0 -> RD then WR, mem_data_in 0xDEAABEEF, rsp 3 cycles after accept.
REQ-036 Byte loads: word 0xDEAABEEF; load 0x01000012, size 0 -> rsp_rdata 0xFFFFFFAA when unsigned=0, 0x000000AA when unsigned=1.
REQ-037 Faults: half load at 0x01000011; word load at 0x00FFFFFC; size 3 -> each gives rsp_fault 1 and rsp_rdata 0 one cycle after accept, with mem_read_write never high.
REQ-038 Reset low during WR of a sub-word store -> mem_read_write drops immediately, no rsp_valid; after release, req_ready 1 and the next load completes normally.
REQ-039 Back-to-back: req_valid held high with two loads -> second accepted the cycle after the first RESP; req_ready low in RD and RESP.
